// File: rtl/dino_jump_ctrl.sv
// ---------------------------------------------------------------------------
// dino_jump_ctrl
//
// Vertical-motion controller for the T-rex player. A four-state FSM
// (RUN / RISE / FALL / DEAD) is advanced by the jump, duck, collision and
// restart inputs. While airborne, a height trajectory is integrated once per
// frame_tick: a fixed launch speed, a constant gravity step and a saturated
// fall speed.
//
// Optional feature (compile-time macro DINO_FAST_FALL_EN):
//   defined     - duck_btn on a RISE tick aborts the climb (FALL, speed 0,
//                 height kept); duck_btn on a FALL tick adds 2*GRAVITY.
//   not defined - duck_btn is ignored while airborne.
//
// Parameters
//   H_WIDTH   height width; must hold JUMP_VEL*(JUMP_VEL+1)/2
//   S_WIDTH   speed register width
//   JUMP_VEL  initial rise speed, pixels/frame
//   GRAVITY   speed change per frame
//   MAX_FALL  fall speed saturation, pixels/frame
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   frame_tick  in   1-cycle pulse per frame; motion updates only on it
//   jump_btn    in   jump button level (already synchronised)
//   duck_btn    in   duck button level (already synchronised)
//   collision   in   obstacle hit, level
//   restart     in   1-cycle pulse; leaves DEAD
//   height      out  dino height above ground (0 = ground)
//   airborne    out  state is RISE or FALL
//   on_ground   out  state is RUN
//   is_duck     out  RUN and duck_btn
//   is_dead     out  state is DEAD
//
// Handshake: there is no valid/ready pairing here. frame_tick is a qualifier
// pulse: every motion update happens on exactly the cycles it is high, and
// holding it low freezes state and height (pausing is done upstream).
//
// All outputs are registered. The flags are computed from the next-state
// value so they change on the same edge as the internal state register.
// ---------------------------------------------------------------------------
module dino_jump_ctrl #(
  parameter int H_WIDTH  = 10,
  parameter int S_WIDTH  = 5,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               jump_btn,
  input  logic               duck_btn,
  input  logic               collision,
  input  logic               restart,
  output logic [H_WIDTH-1:0] height,
  output logic               airborne,
  output logic               on_ground,
  output logic               is_duck,
  output logic               is_dead
);

  // FSM encoding
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  // Parameter values sized to the datapath
  localparam logic [S_WIDTH-1:0] JUMP_S = S_WIDTH'(JUMP_VEL);
  localparam logic [S_WIDTH-1:0] GRAV_S = S_WIDTH'(GRAVITY);
  localparam logic [S_WIDTH:0]   GRAV_X = (S_WIDTH+1)'(GRAVITY);
  localparam logic [S_WIDTH:0]   MAXF_X = (S_WIDTH+1)'(MAX_FALL);

  // State registers
  logic [1:0]         state;
  logic [S_WIDTH-1:0] speed;
  logic               jump_pending;
  logic               jump_btn_q;

  // Next-state values
  logic [1:0]         state_nxt;
  logic [S_WIDTH-1:0] speed_nxt;
  logic [H_WIDTH-1:0] height_nxt;
  logic               pending_nxt;

  // Jump request decode
  logic jump_edge;
  logic jump_req;

  // Fall-step datapath
  logic [S_WIDTH:0]   fall_add;
  logic [S_WIDTH:0]   fall_sum;
  logic [S_WIDTH-1:0] fall_s;
  logic [H_WIDTH-1:0] fall_s_h;
  logic [H_WIDTH-1:0] rise_h;
  logic               fast_abort;

  // A rising edge on the same cycle as the tick must launch on that tick, so
  // the live edge is OR-ed in rather than waiting for jump_pending to load.
  always_comb begin
    jump_edge = jump_btn & ~jump_btn_q;
    jump_req  = jump_pending | jump_edge;
  end

  // Fall speed candidate: one extra bit so speed + gravity cannot wrap
  // before saturation is applied.
  always_comb begin
`ifdef DINO_FAST_FALL_EN
    fall_add   = duck_btn ? (GRAV_X << 1) : GRAV_X;
    fast_abort = duck_btn;
`else
    fall_add   = GRAV_X;
    fast_abort = 1'b0;
`endif
    fall_sum = {1'b0, speed} + fall_add;
    fall_s   = (fall_sum > MAXF_X) ? MAXF_X[S_WIDTH-1:0] : fall_sum[S_WIDTH-1:0];
    fall_s_h = H_WIDTH'(fall_s);
    rise_h   = height + H_WIDTH'(speed);
  end

  // Next-state logic. Priority: collision (outside DEAD) > restart (in DEAD)
  // > frame_tick motion update. rst is handled in the register block.
  always_comb begin
    state_nxt   = state;
    speed_nxt   = speed;
    height_nxt  = height;
    // Pending only survives in RUN between ticks.
    pending_nxt = (state == ST_RUN) ? jump_req : 1'b0;

    if ((state != ST_DEAD) && collision) begin
      // Freeze height and speed where the hit happened.
      state_nxt   = ST_DEAD;
      pending_nxt = 1'b0;
    end else if (state == ST_DEAD) begin
      if (restart) begin
        state_nxt  = ST_RUN;
        height_nxt = '0;
        speed_nxt  = '0;
      end
      pending_nxt = 1'b0;
    end else if (frame_tick) begin
      case (state)
        ST_RUN: begin
          // Every RUN tick consumes the request; ducking drops it.
          pending_nxt = 1'b0;
          if (jump_req && !duck_btn) begin
            state_nxt = ST_RISE;
            speed_nxt = JUMP_S;
          end
        end
        ST_RISE: begin
          if (fast_abort) begin
            state_nxt = ST_FALL;
            speed_nxt = '0;
          end else begin
            height_nxt = rise_h;
            if (speed <= GRAV_S) begin
              state_nxt = ST_FALL;
              speed_nxt = '0;
            end else begin
              speed_nxt = speed - GRAV_S;
            end
          end
        end
        ST_FALL: begin
          // Clamp to ground instead of letting height underflow.
          if (height <= fall_s_h) begin
            state_nxt  = ST_RUN;
            height_nxt = '0;
            speed_nxt  = '0;
          end else begin
            height_nxt = height - fall_s_h;
            speed_nxt  = fall_s;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          height_nxt = '0;
          speed_nxt  = '0;
        end
      endcase
    end
  end

  // Registers, including the output flags derived from state_nxt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      height       <= '0;
      speed        <= '0;
      jump_pending <= 1'b0;
      jump_btn_q   <= 1'b0;
      airborne     <= 1'b0;
      on_ground    <= 1'b1;
      is_duck      <= 1'b0;
      is_dead      <= 1'b0;
    end else begin
      state        <= state_nxt;
      height       <= height_nxt;
      speed        <= speed_nxt;
      jump_pending <= pending_nxt;
      jump_btn_q   <= jump_btn;
      airborne     <= (state_nxt == ST_RISE) || (state_nxt == ST_FALL);
      on_ground    <= (state_nxt == ST_RUN);
      is_duck      <= (state_nxt == ST_RUN) && duck_btn;
      is_dead      <= (state_nxt == ST_DEAD);
    end
  end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dino_jump_ctrl
//
// Self-checking bench for dino_jump_ctrl with default parameters. Expected
// {airborne, on_ground, is_duck, is_dead, height} words are pushed to exp_q
// when a cycle of stimulus is driven and popped after the clock edge that
// should produce them. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_dino_jump_ctrl;

  localparam int HW = 10;
  localparam int OW = HW + 4;

  // flag codes: {airborne, on_ground, is_duck, is_dead}
  localparam logic [3:0] F_RUN  = 4'b0100;
  localparam logic [3:0] F_DUCK = 4'b0110;
  localparam logic [3:0] F_AIR  = 4'b1000;
  localparam logic [3:0] F_DEAD = 4'b0001;

  logic          clk;
  logic          rst;
  logic          frame_tick;
  logic          jump_btn;
  logic          duck_btn;
  logic          collision;
  logic          restart;
  logic [HW-1:0] height;
  logic          airborne;
  logic          on_ground;
  logic          is_duck;
  logic          is_dead;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_v;
  logic [OW-1:0] got_v;
  int            checks;
  int            errors;

  // reference jump arc from the ground: 12 rise ticks, 13 fall ticks, landing
  int arc[26];

  dino_jump_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .jump_btn   (jump_btn),
    .duck_btn   (duck_btn),
    .collision  (collision),
    .restart    (restart),
    .height     (height),
    .airborne   (airborne),
    .on_ground  (on_ground),
    .is_duck    (is_duck),
    .is_dead    (is_dead)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] obs();
    return {airborne, on_ground, is_duck, is_dead, height};
  endfunction

  function automatic logic [OW-1:0] mk(input logic [3:0] f, input int h);
    return {f, HW'(h)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic t);
    frame_tick = t;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  // jump edge on a non-tick cycle, then the launch tick (RISE, height 0)
  task automatic launch();
    jump_btn = 1'b1;
    step(1'b0);
    jump_btn = 1'b0;
    step(1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    got_v = obs();
    checks++;
    if (got_v !== mk(F_RUN, 0)) begin
      errors++;
      $display("FAIL reset got %h want %h", got_v, mk(F_RUN, 0));
    end
  endtask

  task automatic test_jump_arc();
    launch();
    got_v = obs();
    checks++;
    if (got_v !== mk(F_AIR, 0)) begin
      errors++;
      $display("FAIL arc_launch got %h want %h", got_v, mk(F_AIR, 0));
    end
    for (int i = 0; i < 26; i++) begin
      exp_q.push_back(mk((i == 25) ? F_RUN : F_AIR, arc[i]));
      step(1'b1);
      exp_v = exp_q.pop_front();
      got_v = obs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL arc[%0d] got %h want %h", i, got_v, exp_v);
      end
      // mid-air pause: no ticks must hold height
      if (i == 5) begin
        exp_q.push_back(mk(F_AIR, arc[5]));
        repeat (4) step(1'b0);
        exp_v = exp_q.pop_front();
        got_v = obs();
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL arc_pause got %h want %h", got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_collision();
    launch();
    step(1'b1);
    step(1'b1);
    collision = 1'b1;
    exp_q.push_back(mk(F_DEAD, 23));
    step(1'b0);
    collision = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL coll_dead got %h want %h", got_v, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(F_DEAD, 23));
      step(1'b1);
      exp_v = exp_q.pop_front();
      got_v = obs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL dead_hold[%0d] got %h want %h", i, got_v, exp_v);
      end
    end
    restart = 1'b1;
    exp_q.push_back(mk(F_RUN, 0));
    step(1'b0);
    restart = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL restart got %h want %h", got_v, exp_v);
    end
    restart = 1'b1;
    exp_q.push_back(mk(F_RUN, 0));
    step(1'b1);
    restart = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL restart_in_run got %h want %h", got_v, exp_v);
    end
  endtask

  task automatic test_duck();
    duck_btn = 1'b1;
    jump_btn = 1'b1;
    exp_q.push_back(mk(F_DUCK, 0));
    step(1'b1);
    jump_btn = 1'b0;
    exp_q.push_back(mk(F_DUCK, 0));
    step(1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      if (i == 0) got_v = obs();
      checks++;
      if (i == 1) got_v = obs();
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL duck_drop[%0d] got %h want %h", i, got_v, exp_v);
      end
    end
    duck_btn = 1'b0;
    exp_q.push_back(mk(F_RUN, 0));
    step(1'b1);
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL duck_release got %h want %h", got_v, exp_v);
    end
    // edge coinciding with a tick launches on that tick; hold through landing
    jump_btn = 1'b1;
    exp_q.push_back(mk(F_AIR, 0));
    step(1'b1);
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL edge_on_tick got %h want %h", got_v, exp_v);
    end
    for (int i = 0; i < 26; i++) step(1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(F_RUN, 0));
      step(1'b1);
      exp_v = exp_q.pop_front();
      got_v = obs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL hold_no_repeat[%0d] got %h want %h", i, got_v, exp_v);
      end
    end
    jump_btn = 1'b0;
    step(1'b0);
    jump_btn = 1'b1;
    exp_q.push_back(mk(F_AIR, 0));
    step(1'b1);
    jump_btn = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rejump got %h want %h", got_v, exp_v);
    end
    for (int i = 0; i < 26; i++) step(1'b1);
  endtask

  task automatic test_back_to_back();
    // collision and restart together in DEAD: restart wins
    collision = 1'b1;
    step(1'b0);
    restart = 1'b1;
    exp_q.push_back(mk(F_RUN, 0));
    step(1'b0);
    restart   = 1'b0;
    collision = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL restart_vs_coll got %h want %h", got_v, exp_v);
    end
    // reset mid-air at height 50
    launch();
    for (int i = 0; i < 5; i++) step(1'b1);
    exp_q.push_back(mk(F_AIR, 50));
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL pre_rst_50 got %h want %h", got_v, exp_v);
    end
    rst = 1'b1;
    exp_q.push_back(mk(F_RUN, 0));
    step(1'b1);
    rst = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rst_midair got %h want %h", got_v, exp_v);
    end
    // reset out of DEAD
    collision = 1'b1;
    step(1'b0);
    collision = 1'b0;
    rst = 1'b1;
    exp_q.push_back(mk(F_RUN, 0));
    step(1'b0);
    rst = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL rst_dead got %h want %h", got_v, exp_v);
    end
  endtask

  task automatic test_airborne_duck();
    int ff_h[5];
    ff_h = '{21, 17, 11, 3, 0};
    launch();
    step(1'b1);
    step(1'b1);
    duck_btn = 1'b1;
`ifdef DINO_FAST_FALL_EN
    exp_q.push_back(mk(F_AIR, 23));
    step(1'b1);
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL ff_abort got %h want %h", got_v, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk((i == 4) ? F_DUCK : F_AIR, ff_h[i]));
      step(1'b1);
      exp_v = exp_q.pop_front();
      got_v = obs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL ff_fall[%0d] got %h want %h", i, got_v, exp_v);
      end
    end
    duck_btn = 1'b0;
    step(1'b0);
`else
    exp_q.push_back(mk(F_AIR, 33));
    step(1'b1);
    duck_btn = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = obs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL duck_air_ignored got %h want %h (alt %h)", got_v, exp_v, mk(F_AIR, ff_h[0]));
    end
    for (int i = 3; i < 26; i++) begin
      exp_q.push_back(mk((i == 25) ? F_RUN : F_AIR, arc[i]));
      step(1'b1);
      exp_v = exp_q.pop_front();
      got_v = obs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL duck_arc[%0d] got %h want %h", i, got_v, exp_v);
      end
    end
`endif
    got_v = obs();
    checks++;
    if (got_v !== mk(F_RUN, 0)) begin
      errors++;
      $display("FAIL after_land got %h want %h", got_v, mk(F_RUN, 0));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
    duck_btn   = 1'b0;
    collision  = 1'b0;
    restart    = 1'b0;
    arc = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
            77, 75, 72, 68, 63, 57, 50, 42, 34, 26, 18, 10, 2, 0};

    test_reset();
    test_jump_arc();
    test_collision();
    test_duck();
    test_back_to_back();
    test_airborne_duck();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
